// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// reset_sequencer
// ---------------
// Reset generator for a clock domain with several dependent reset domains
// (for example pixel, system and peripheral). Reset is asserted
// asynchronously by arst_n and released synchronously. Release waits for a
// synchronized clock-lock indication, is held for HOLD_CYCLES consecutive
// good cycles, and then drops the per-channel resets one after another,
// GAP_CYCLES idle cycles apart. Losing lock or requesting a soft reset at any
// point after release puts every channel back into reset and restarts
// qualification.
//
// Ports:
//   clk      in   system or pixel clock
//   arst_n   in   asynchronous reset, active-low
//   locked   in   clock-wizard lock, asynchronous to clk
//   soft_rst in   synchronous reset request, active-high
//   srst     out  per-channel synchronous reset, active-high; srst[0] first
//   ready    out  high once every channel has been released
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int NUM_CH      = 2,
   parameter int GAP_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              locked,
   input  logic              soft_rst,
   output logic [NUM_CH-1:0] srst,
   output logic              ready
);

   localparam int HOLD_W_RAW = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W_RAW  = $clog2(GAP_CYCLES + 1);
   localparam int IDX_W_RAW  = $clog2(NUM_CH + 1);
   localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
   localparam int GAP_W      = (GAP_W_RAW < 1) ? 1 : GAP_W_RAW;
   localparam int IDX_W      = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0] ALL_ON    = '1;

   typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   rst_q;
   logic                   lock_q;
   logic                   qualified;
   logic                   abort;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_CH-1:0]      srst_q, srst_d;
   logic                   ready_q, ready_d;

   // Synchronizer stage: reset-release chain (D tied high) and lock chain,
   // both cleared the moment arst_n falls.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
      end
   end

   assign rst_q     = rst_sync_q[SYNC_STAGES-1];
   assign lock_q    = lock_sync_q[SYNC_STAGES-1];
   assign qualified = rst_q && lock_q && !soft_rst;
   // Lock loss outranks soft reset, but both lead to the same abort action.
   assign abort     = !lock_q || soft_rst;

   // Sequencing stage: next-state and next-output decode.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      idx_d      = idx_q;
      srst_d     = srst_q;
      ready_d    = ready_q;

      unique case (state_q)
         HOLD: begin
            srst_d    = ALL_ON;
            ready_d   = 1'b0;
            gap_cnt_d = '0;
            idx_d     = '0;
            if (!qualified) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               // Channel 0 drops on the very edge that ends qualification.
               hold_cnt_d = '0;
               srst_d     = ALL_ON << 1;
               idx_d      = IDX_W'(1);
               if (NUM_CH == 1) begin
                  ready_d = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         RELEASE: begin
            if (abort) begin
               state_d    = HOLD;
               srst_d     = ALL_ON;
               ready_d    = 1'b0;
               hold_cnt_d = '0;
               gap_cnt_d  = '0;
               idx_d      = '0;
            end else if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               for (int k = 0; k < NUM_CH; k++) begin
                  if (idx_q == IDX_W'(k)) srst_d[k] = 1'b0;
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  ready_d = 1'b1;
                  state_d = RUN;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         RUN: begin
            if (abort) begin
               state_d    = HOLD;
               srst_d     = ALL_ON;
               ready_d    = 1'b0;
               hold_cnt_d = '0;
               gap_cnt_d  = '0;
               idx_d      = '0;
            end
         end

         default: begin
            state_d = HOLD;
            srst_d  = ALL_ON;
            ready_d = 1'b0;
         end
      endcase
   end

   // Output register stage: every output comes straight from a flop.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= HOLD;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         idx_q      <= '0;
         srst_q     <= ALL_ON;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         idx_q      <= idx_d;
         srst_q     <= srst_d;
         ready_q    <= ready_d;
      end
   end

   assign srst  = srst_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

   localparam int NCFG = 4;
   // Per-configuration parameters, one byte per config (config 0 in the low byte).
   //   cfg0: defaults          cfg1: NUM_CH=1 GAP=0
   //   cfg2: NUM_CH=4 GAP=0    cfg3: SYNC=3 HOLD=1
   localparam logic [31:0] C_SYNC = {8'd3, 8'd2, 8'd2, 8'd2};
   localparam logic [31:0] C_HOLD = {8'd1, 8'd16, 8'd16, 8'd16};
   localparam logic [31:0] C_NC   = {8'd2, 8'd4, 8'd1, 8'd2};
   localparam logic [31:0] C_GAP  = {8'd4, 8'd0, 8'd0, 8'd4};

   logic clk = 1'b0;
   logic arst_n = 1'b1;
   logic locked = 1'b1;
   logic soft_rst = 1'b0;

   logic [NCFG-1:0][3:0] srst_w;
   logic [NCFG-1:0]      ready_w;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   function automatic void check(input string name, input int g,
                                 input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
      end
   endfunction

   // Hand-computed release edges (counted from the first clock after arst_n rises).
   function automatic int lit_rel(input int g, input int k);
      case (g)
         0:       return (k == 0) ? 18 : 23;
         1:       return 18;
         2:       return 18 + k;
         default: return (k == 0) ? 4 : 9;
      endcase
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int SY = int'(C_SYNC[g*8 +: 8]);
      localparam int HO = int'(C_HOLD[g*8 +: 8]);
      localparam int NC = int'(C_NC[g*8 +: 8]);
      localparam int GA = int'(C_GAP[g*8 +: 8]);

      logic [NC-1:0] srst_g;
      logic          ready_g;

      reset_sequencer #(
         .SYNC_STAGES(SY),
         .HOLD_CYCLES(HO),
         .NUM_CH(NC),
         .GAP_CYCLES(GA)
      ) dut (
         .clk(clk),
         .arst_n(arst_n),
         .locked(locked),
         .soft_rst(soft_rst),
         .srst(srst_g),
         .ready(ready_g)
      );

      assign srst_w[g]  = 4'(srst_g);
      assign ready_w[g] = ready_g;

      // Behavioural model: edges since reset release, a history of locked
      // samples, a run-length of good cycles, and time elapsed since the
      // first channel was released. Channel k is out of reset once
      // (GAP+1)*k edges have elapsed since release.
      bit hist [8];
      int age    = 0;
      int streak = 0;
      int el     = 0;
      bit rel    = 1'b0;
      bit lq, rq;

      initial forever begin
         @(posedge clk or negedge arst_n);
         if (!arst_n) begin
            for (int k = 0; k < 8; k++) hist[k] = 1'b0;
            age = 0; streak = 0; el = 0; rel = 1'b0;
         end else begin
            lq = hist[SY-1];
            rq = (age >= SY);
            if (!rel) begin
               if (rq && lq && !soft_rst) streak++;
               else streak = 0;
               if (streak == HO) begin
                  rel = 1'b1; el = 0; streak = 0;
               end
            end else if (!lq || soft_rst) begin
               rel = 1'b0; streak = 0; el = 0;
            end else if (el < 1000000) begin
               el++;
            end
            for (int k = SY - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = locked;
            if (age < 1000000) age++;
         end
      end

      logic [NC-1:0] exp_s;
      logic [NC-1:0] inv;
      logic          exp_r;

      initial forever begin
         @(negedge clk);
         for (int k = 0; k < NC; k++) exp_s[k] = !(rel && (el >= (GA + 1) * k));
         exp_r = rel && (el >= (GA + 1) * (NC - 1));
         check("model_srst", g, 32'(srst_g), 32'(exp_s));
         check("model_ready", g, 32'(ready_g), 32'(exp_r));
         inv = ~srst_g;
         check("in_order", g, 32'((inv & (inv + 1'b1)) == '0), 32'd1);
         check("ready_vs_srst", g, 32'(ready_g), 32'(srst_g == '0));
         if (age < SY) check("held_in_sync", g, 32'(srst_g), 32'((1 << NC) - 1));
      end
   end

   task automatic check_all_on(input string name);
      for (int g = 0; g < NCFG; g++) begin
         int nc;
         nc = int'(C_NC[g*8 +: 8]);
         check(name, g, 32'(srst_w[g]), 32'((1 << nc) - 1));
         check({name, "_ready"}, g, 32'(ready_w[g]), 32'd0);
      end
   endtask

   task automatic check_lit(input string name, input int e);
      for (int g = 0; g < NCFG; g++) begin
         int nc;
         logic [3:0] es;
         nc = int'(C_NC[g*8 +: 8]);
         es = '0;
         for (int k = 0; k < nc; k++) es[k] = (e < lit_rel(g, k));
         check(name, g, 32'(srst_w[g]), 32'(es));
         check({name, "_ready"}, g, 32'(ready_w[g]), 32'(e >= lit_rel(g, nc - 1)));
      end
   endtask

   task automatic check_c0(input string name, input int e, input int r0, input int r1);
      logic [3:0] es;
      es = {2'b00, 1'(e < r1), 1'(e < r0)};
      check(name, 0, 32'(srst_w[0]), 32'(es));
      check({name, "_ready"}, 0, 32'(ready_w[0]), 32'(e >= r1));
   endtask

   // Drop arst_n between edges, check outputs before any clock, then release
   // so that the next rising edge is edge 1.
   task automatic do_reset(input string name, input int low_cycles);
      @(posedge clk);
      #2 arst_n = 1'b0;
      #1 check_all_on(name);
      repeat (low_cycles) @(posedge clk);
      #2 arst_n = 1'b1;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d;
      #1 arst_n = 1'b0;

      // Power-on sequence for every configuration.
      do_reset("por_low", 3);
      for (int e = 1; e <= 30; e++) begin
         next_edge();
         check_lit("por_seq", e);
      end

      // arst_n dropped while cfg0 is between its two channel releases.
      do_reset("pre_mid", 2);
      for (int e = 1; e <= 20; e++) begin
         next_edge();
         check_lit("pre_mid_seq", e);
      end
      do_reset("mid_release_low", 3);
      for (int e = 1; e <= 30; e++) begin
         next_edge();
         check_lit("after_mid_seq", e);
      end

      // locked low for exactly the sample at edge 10 of HOLD.
      do_reset("lock_glitch_low", 3);
      for (int e = 1; e <= 36; e++) begin
         next_edge();
         check_c0("lock_glitch_seq", e, 28, 33);
         if (e == 9)  locked = 1'b0;
         if (e == 10) locked = 1'b1;
      end

      // One-cycle soft reset while cfg0 is running.
      soft_rst = 1'b1;
      for (int dd = 0; dd <= 25; dd++) begin
         next_edge();
         soft_rst = 1'b0;
         check_c0("soft_rst_seq", dd, 16, 21);
      end

      // Random asynchronous arst_n / locked activity, with occasional soft resets.
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(posedge clk);
         d = $urandom_range(1, 3);
         #(d);
         if (arst_n) begin
            if ($urandom_range(0, 99) < 2) arst_n = 1'b0;
         end else if ($urandom_range(0, 99) < 25) begin
            arst_n = 1'b1;
         end
         if (locked) begin
            if ($urandom_range(0, 99) < 2) locked = 1'b0;
         end else if ($urandom_range(0, 99) < 30) begin
            locked = 1'b1;
         end
         soft_rst = ($urandom_range(0, 99) < 1);
      end

      @(posedge clk);
      #2;
      arst_n   = 1'b1;
      locked   = 1'b1;
      soft_rst = 1'b0;
      repeat (5) @(posedge clk);

      do_reset("final_low", 3);
      for (int e = 1; e <= 30; e++) begin
         next_edge();
         check_lit("final_seq", e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
